ram_bank: RTL and testbench
===========================

// Module: ram_bank
// PURPOSE
//   Parametrised single-port synchronous RAM; next generation of the 32x32 ram.
//   Adds byte-lane write enables, a read-valid strobe and a selectable read-during-write mode.
//   Adds a post-reset clear sequencer and out-of-range address detection.
//   Serves as the operand/result store beside the ALU/multiplier datapath.
// PARAMETERS
//   DATA_W    32  word width in bits; must be a multiple of 8
//   ADDR_W    5   address width
//   DEPTH     32  number of words; 1 <= DEPTH <= 2**ADDR_W
//   RDW_MODE  0   read-during-write on the same word: 0 = old data, 1 = new (merged) data
// PORTS
//   clk       in   1         clock; all state changes on its rising edge
//   reset_n   in   1         synchronous, active-low reset
//   cen       in   1         chip enable; 0 = no access
//   wen       in   1         1 = write, 0 = read (qualified by cen)
//   be        in   DATA_W/8  byte-lane write enables; be[i] gates din[8i+7:8i]
//   addr      in   ADDR_W    word address
//   din       in   DATA_W    write data
//   dout      out  DATA_W    registered read data
//   dvalid    out  1         1-cycle pulse: dout updated by a read
//   busy      out  1         clear sequencer active; all accesses are ignored
//   addr_err  out  1         1-cycle pulse: accepted access had addr >= DEPTH
// BEHAVIOUR
//   Reset: reset_n sampled low -> next edge: dout=0, dvalid=0, addr_err=0, busy=1,
//     FSM=CLEAR, clr_ptr=0. Memory contents are not reset directly.
//   FSM CLEAR: writes 0 to word clr_ptr each cycle and increments clr_ptr.
//     After writing word DEPTH-1, moves to READY. busy=1 for exactly DEPTH cycles after reset release.
//   FSM READY: busy=0; stays in READY until the next reset.
//   Reset mid-clear: sequence restarts from clr_ptr=0.
//   Access accepted iff FSM=READY && cen=1; otherwise dout holds, dvalid=0, addr_err=0.
//   Read (wen=0): dout <= mem[addr] at the next edge; dvalid=1 for that cycle only (latency 1).
//   Write (wen=1): for each i with be[i]=1, byte i of mem[addr] <= byte i of din.
//     be=0 is a legal no-op. A write never updates dout and gives dvalid=0.
//   Same-word read-during-write (single port) only arises via the read port of a write cycle.
//     RDW_MODE=1: a write cycle also drives dout with the merged word and pulses dvalid.
//     RDW_MODE=0: dout holds.
//   addr >= DEPTH (only possible when DEPTH < 2**ADDR_W): write dropped, read returns dout=0
//     with dvalid=1; addr_err=1 for one cycle in both cases.
//   cen=0 or idle: dout keeps its last value indefinitely.
// CONFIGURATION
//   RAM_PARITY_EN defined:
//     One even-parity bit is stored per byte lane, written with each byte (and by CLEAR as 0).
//     On every read, the parity of the stored bytes is checked.
//     Extra output port parity_err (out, 1): pulses with dvalid when any lane mismatches.
//     Extra input port par_inj (in, 1): inverts the stored parity of the lanes being written, for test.
//   RAM_PARITY_EN undefined: no parity storage, no parity_err/par_inj ports, no extra logic.
// STRUCTURE
//   Shared package ram_pkg: FSM state encoding (ST_CLEAR, ST_READY).
//   Shared package ram_pkg: RDW_OLD/RDW_NEW constants and function byte_merge(old, din, be).
//   Sub-module ram_clear_seq: CLEAR/READY FSM, clr_ptr counter, busy output.
//   Sub-module ram_clear_seq supplies the internal write port to the array during CLEAR.
//   Top level: storage array, byte merge, read register, error flags.
// TESTING
//   1 Reset, then poll busy -> busy=1 for exactly 32 cycles; then read addr 0..31 -> all dout=0, dvalid each.
//   2 Write 0x1111_1111 @1, 0x2222_2222 @2, 0x3333_3333 @3 (be=4'hF); read 1,2,3 -> same values, 1-cycle latency.
//   3 Write @5 0xAABB_CCDD be=4'hF, then 0x1122_3344 be=4'b0101; read @5 -> 0xAA22_CC44.
//   4 cen=0, addr sweep 1..3, din=0xFFFF_FFFF -> dout holds last read, dvalid=0, memory unchanged.
//   5 DEPTH=20: write/read @25 -> addr_err pulse, no write, dout=0; RDW_MODE=1 write @3 -> dout=merged word.
//   6 reset_n low at clear cycle 10 -> busy stays 1, clear restarts, READY 32 cycles after release;
//     with RAM_PARITY_EN, par_inj write then read -> parity_err=1 with dvalid.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the ram_bank slice: sequencer states, read-during-write
// mode constants and the byte-lane merge helper.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                              input logic [7:0] din_b,
                                              input logic       be_b);
        return be_b ? din_b : old_b;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: zeroes every word once, then parks in READY.
// Owns the array write port while busy.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        busy     = 1'b0;
        clr_we   = 1'b0;
        clr_addr = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (ptr_q == LAST) begin
                    state_d = ST_READY;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_READY: ;
        endcase
    end

endmodule

// File: rtl/ram_bank.sv
// Single-port byte-writable RAM with read-valid strobe, post-reset clear and
// out-of-range detection. Define RAM_PARITY_EN for per-lane even parity.
module ram_bank
    import ram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int RDW_MODE = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cen,
    input  logic                wen,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   din,
    output logic [DATA_W-1:0]   dout,
    output logic                dvalid,
    output logic                busy,
`ifdef RAM_PARITY_EN
    output logic                parity_err,
    input  logic                par_inj,
`endif
    output logic                addr_err
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    ram_clear_seq #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_clr (
        .clk      (clk),
        .reset_n  (reset_n),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic              acc, in_range;
    logic [ADDR_W-1:0] rd_idx, wr_idx;
    logic [DATA_W-1:0] old_word, merged, wr_data;
    logic              wr_en;

    assign acc      = cen && !busy;
    assign in_range = {1'b0, addr} < (ADDR_W+1)'(DEPTH);
    // Out-of-range addresses never touch the array index.
    assign rd_idx   = in_range ? addr : '0;
    assign old_word = mem_q[rd_idx];

    always_comb begin
        merged = old_word;
        for (int i = 0; i < NB; i++)
            merged[8*i +: 8] = byte_merge(old_word[8*i +: 8], din[8*i +: 8], be[i]);
    end

    always_comb begin
        wr_en   = acc && wen && in_range;
        wr_idx  = addr;
        wr_data = merged;
        if (busy) begin
            wr_en   = clr_we;
            wr_idx  = clr_addr;
            wr_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= wr_data;
    end

    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dvalid_q, dvalid_d;
    logic              addr_err_q, addr_err_d;

    always_comb begin
        dout_d     = dout_q;
        dvalid_d   = 1'b0;
        addr_err_d = 1'b0;
        if (acc) begin
            if (!in_range) begin
                addr_err_d = 1'b1;
                if (!wen) begin
                    dout_d   = '0;
                    dvalid_d = 1'b1;
                end
            end else if (!wen) begin
                dout_d   = old_word;
                dvalid_d = 1'b1;
            end else if (RDW_MODE == RDW_NEW) begin
                dout_d   = merged;
                dvalid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dout_q     <= '0;
            dvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            dvalid_q   <= dvalid_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign dout     = dout_q;
    assign dvalid   = dvalid_q;
    assign addr_err = addr_err_q;

`ifdef RAM_PARITY_EN
    logic [NB-1:0] par_mem_q [DEPTH];
    logic [NB-1:0] old_par, wr_par, calc_par;
    logic          parity_err_q, parity_err_d;

    assign old_par = par_mem_q[rd_idx];

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            calc_par[i] = ^old_word[8*i +: 8];
            wr_par[i]   = be[i] ? ((^din[8*i +: 8]) ^ par_inj) : old_par[i];
        end
        if (busy) wr_par = '0;
        parity_err_d = acc && !wen && in_range && |(calc_par ^ old_par);
    end

    always_ff @(posedge clk) begin
        if (wr_en) par_mem_q[wr_idx] <= wr_par;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) parity_err_q <= 1'b0;
        else          parity_err_q <= parity_err_d;
    end

    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_ram_bank.sv
// Scoreboard bench for ram_bank: a 32-word old-data instance and a 20-word
// new-data instance share stimulus; a monitor checks each against its model.
module tb_ram_bank;

    logic        clk = 1'b0;
    logic        reset_n, cen, wen, par_inj;
    logic [3:0]  be;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] dout0, dout1;
    logic        dvalid0, dvalid1, busy0, busy1, addr_err0, addr_err1;
    logic        pe0, pe1;

    always #5 clk = ~clk;

    ram_bank u0 (
        .clk(clk), .reset_n(reset_n), .cen(cen), .wen(wen), .be(be), .addr(addr),
        .din(din), .dout(dout0), .dvalid(dvalid0), .busy(busy0),
`ifdef RAM_PARITY_EN
        .parity_err(pe0), .par_inj(par_inj),
`endif
        .addr_err(addr_err0)
    );

    ram_bank #(.DEPTH(20), .RDW_MODE(1)) u1 (
        .clk(clk), .reset_n(reset_n), .cen(cen), .wen(wen), .be(be), .addr(addr),
        .din(din), .dout(dout1), .dvalid(dvalid1), .busy(busy1),
`ifdef RAM_PARITY_EN
        .parity_err(pe1), .par_inj(par_inj),
`endif
        .addr_err(addr_err1)
    );

`ifndef RAM_PARITY_EN
    assign pe0 = 1'b0;
    assign pe1 = 1'b0;
`endif

    typedef struct {
        logic        dv;
        logic        ae;
        logic        pe;
        logic [31:0] d;
    } rec_t;

    rec_t        q0[$], q1[$];
    logic [31:0] mm [2][32];
    logic [3:0]  pm [2][32];
    logic [31:0] ld [2];
    int          dep [2] = '{32, 20};
    int          rdw [2] = '{0, 1};
    int          n_chk = 0, n_fail = 0;
    bit          started = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int j = 0; j < 2; j++) begin
            ld[j] = '0;
            for (int a = 0; a < 32; a++) begin
                mm[j][a] = '0;
                pm[j][a] = '0;
            end
        end
    endtask

    task automatic model_step(input int j, input logic c, input logic w, input logic [3:0] b,
                              input logic [4:0] a, input logic [31:0] di, input logic inj,
                              output rec_t r);
        r.dv = 0; r.ae = 0; r.pe = 0;
        if (c) begin
            if (int'(a) >= dep[j]) begin
                r.ae = 1;
                if (!w) begin ld[j] = '0; r.dv = 1; end
            end else if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) begin
                        mm[j][a][8*i +: 8] = di[8*i +: 8];
                        pm[j][a][i]        = (^di[8*i +: 8]) ^ inj;
                    end
                if (rdw[j] == 1) begin ld[j] = mm[j][a]; r.dv = 1; end
            end else begin
                ld[j] = mm[j][a];
                r.dv  = 1;
                for (int i = 0; i < 4; i++)
                    if ((^mm[j][a][8*i +: 8]) != pm[j][a][i]) r.pe = 1;
            end
        end
        r.d = ld[j];
    endtask

    task automatic access(input logic c, input logic w, input logic [3:0] b,
                          input logic [4:0] a, input logic [31:0] di, input logic inj);
        rec_t r;
        @(negedge clk);
        cen = c; wen = w; be = b; addr = a; din = di; par_inj = inj;
        model_step(0, c, w, b, a, di, inj, r); q0.push_back(r);
        model_step(1, c, w, b, a, di, inj, r); q1.push_back(r);
    endtask

    task automatic idle();
        access(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b0);
    endtask

    task automatic do_reset(input int mid);
        int c0, c1, n;
        @(negedge clk);
        cen = 0; reset_n = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        started = 1;
        model_clear();
        if (mid > 0) begin
            repeat (mid) @(negedge clk);
            chk("busy_mid_clear", {31'b0, busy0}, 32'd1);
            reset_n = 0;
            @(negedge clk);
            reset_n = 1;
        end
        c0 = 0; c1 = 0; n = 0;
        while ((busy0 || busy1) && n < 200) begin
            if (busy0) c0++;
            if (busy1) c1++;
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            n_chk++; n_fail++;
            $display("FAIL busy_timeout: busy still high after %0d cycles", n);
        end
        chk("busy_cycles_d32", c0, 32'd32);
        chk("busy_cycles_d20", c1, 32'd20);
    endtask

    initial begin
        rec_t r;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                r = q0.pop_front();
                chk("u0_dvalid", {31'b0, dvalid0}, {31'b0, r.dv});
                chk("u0_addr_err", {31'b0, addr_err0}, {31'b0, r.ae});
                chk("u0_dout", dout0, r.d);
`ifdef RAM_PARITY_EN
                if (r.dv) chk("u0_parity_err", {31'b0, pe0}, {31'b0, r.pe});
`endif
            end else if (started) begin
                chk("u0_idle_dvalid", {31'b0, dvalid0}, 32'd0);
            end
            if (q1.size() > 0) begin
                r = q1.pop_front();
                chk("u1_dvalid", {31'b0, dvalid1}, {31'b0, r.dv});
                chk("u1_addr_err", {31'b0, addr_err1}, {31'b0, r.ae});
                chk("u1_dout", dout1, r.d);
`ifdef RAM_PARITY_EN
                if (r.dv) chk("u1_parity_err", {31'b0, pe1}, {31'b0, r.pe});
`endif
            end else if (started) begin
                chk("u1_idle_addr_err", {31'b0, addr_err1}, 32'd0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 0; cen = 0; wen = 0; be = 0; addr = 0; din = 0; par_inj = 0;
        model_clear();

        // cleared contents after reset
        do_reset(0);
        for (int a = 0; a < 32; a++) access(1, 0, 4'h0, 5'(a), 32'h0, 0);
        idle();

        // full-word writes then reads
        access(1, 1, 4'hF, 5'd1, 32'h1111_1111, 0);
        access(1, 1, 4'hF, 5'd2, 32'h2222_2222, 0);
        access(1, 1, 4'hF, 5'd3, 32'h3333_3333, 0);
        for (int a = 1; a <= 3; a++) access(1, 0, 4'h0, 5'(a), 32'h0, 0);
        idle();

        // byte-lane merge
        access(1, 1, 4'hF, 5'd5, 32'hAABB_CCDD, 0);
        access(1, 1, 4'b0101, 5'd5, 32'h1122_3344, 0);
        access(1, 0, 4'h0, 5'd5, 32'h0, 0);
        access(1, 1, 4'h0, 5'd5, 32'hFFFF_FFFF, 0);
        access(1, 0, 4'h0, 5'd5, 32'h0, 0);
        idle();

        // chip enable low: nothing happens, dout holds
        for (int a = 1; a <= 3; a++) access(0, 1, 4'hF, 5'(a), 32'hFFFF_FFFF, 0);
        for (int a = 1; a <= 3; a++) access(0, 0, 4'h0, 5'(a), 32'hFFFF_FFFF, 0);
        for (int a = 1; a <= 3; a++) access(1, 0, 4'h0, 5'(a), 32'h0, 0);
        idle();

        // out of range on the 20-word bank, new-data read-during-write
        access(1, 1, 4'hF, 5'd25, 32'hDEAD_BEEF, 0);
        access(1, 0, 4'h0, 5'd25, 32'h0, 0);
        access(1, 1, 4'b0011, 5'd3, 32'h0000_5A5A, 0);
        access(1, 0, 4'h0, 5'd3, 32'h0, 0);
        access(1, 0, 4'h0, 5'd19, 32'h0, 0);
        access(1, 0, 4'h0, 5'd20, 32'h0, 0);
        idle();

        // randomized traffic
        for (int k = 0; k < 400; k++)
            access(($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
                   5'($urandom), $urandom, 0);
        idle();

`ifdef RAM_PARITY_EN
        access(1, 1, 4'b0100, 5'd7, 32'h0102_0304, 1);
        access(1, 0, 4'h0, 5'd7, 32'h0, 0);
        access(1, 1, 4'hF, 5'd8, 32'h0F0F_0F01, 0);
        access(1, 0, 4'h0, 5'd8, 32'h0, 0);
        idle();
`endif

        // reset in the middle of the clear sequence
        do_reset(10);
        for (int a = 0; a < 32; a += 3) access(1, 0, 4'h0, 5'(a), 32'h0, 0);
        idle();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
